serial_mac_unit: RTL

SERIAL_MAC_UNIT -- requirements
Module: serial_mac_unit

---
 rtl/serial_mac_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_mac_unit.sv
// serial_mac_unit: serially loaded unsigned shift-add multiplier with an
// optional wrapping accumulator (compile with SERIAL_MAC_ACCUM_EN).
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   data_in  DATA_W-bit chunk, captured on each accepted valid edge
//   valid    raw asynchronous load strobe (synchronised and debounced here)
//   mode     0 = multiply, 1 = multiply-accumulate (accumulator build only)
//   sel      byte select into the visible result
//   out      selected result byte (0x00 above ACC_W)
//   busy     high while the shift-add multiply runs
//   done     one-cycle pulse when the result register updates
module serial_mac_unit #(
    parameter int DATA_W    = 4,
    parameter int OP_W      = 8,
    parameter int DB_CYCLES = 4,
    parameter int ACC_W     = 24
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  data_in,
    input  logic                               valid,
    input  logic                               mode,
    input  logic [$clog2((ACC_W+7)/8)-1:0]     sel,
    output logic [7:0]                         out,
    output logic                               busy,
    output logic                               done
);

    localparam int PW     = 2 * OP_W;
    localparam int NCHUNK = PW / DATA_W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BW     = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam int SEL_W  = $clog2((ACC_W + 7) / 8);
    localparam int EXT_W  = 8 << SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MUL,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Synchroniser and debouncer for the raw strobe
    logic       sync1_q, sync2_q;
    logic       stable_q, stable_dly_q;
    logic [7:0] db_cnt_q;
    logic       load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= valid;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            // Any clock where the synced level agrees restarts the count
            if (sync2_q != stable_q) begin
                if (db_cnt_q == 8'(DB_CYCLES - 1)) begin
                    stable_q <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 8'd1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign load = stable_q & ~stable_dly_q;

    // Loader and multiplier datapath
    logic [PW-1:0]     sr_q;
    logic [PW-1:0]     sr_nxt;
    logic [CW-1:0]     chunk_q;
    logic [PW-1:0]     a_q;
    logic [OP_W-1:0]   b_q;
    logic [PW-1:0]     part_q;
    logic [PW-1:0]     psum;
    logic [BW-1:0]     bit_q;
    logic [PW-1:0]     prod_q;
    logic              accept;
    logic              last_chunk;
    logic              mul_last;

    assign accept     = load && (state_q == IDLE || state_q == LOAD);
    assign last_chunk = (chunk_q == CW'(NCHUNK - 1));
    assign mul_last   = (bit_q == BW'(OP_W - 1));
    assign sr_nxt     = {sr_q[PW-DATA_W-1:0], data_in};
    assign psum       = part_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    state_d = last_chunk ? MUL : LOAD;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            chunk_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            bit_q   <= '0;
            prod_q  <= '0;
        end else if (accept) begin
            sr_q <= sr_nxt;
            if (last_chunk) begin
                chunk_q <= '0;
                a_q     <= {{OP_W{1'b0}}, sr_nxt[PW-1:OP_W]};
                b_q     <= sr_nxt[OP_W-1:0];
                part_q  <= '0;
                bit_q   <= '0;
            end else begin
                chunk_q <= chunk_q + 1'b1;
            end
        end else if (state_q == MUL) begin
            // One multiplier bit per clock, LSB first
            part_q <= psum;
            a_q    <= a_q << 1;
            b_q    <= b_q >> 1;
            bit_q  <= bit_q + 1'b1;
            if (mul_last) begin
                prod_q <= psum;
            end
        end
    end

    logic [EXT_W-1:0] vis;

`ifdef SERIAL_MAC_ACCUM_EN
    logic [ACC_W-1:0] acc_q;
    logic             mode_q;

    // mode is frozen at MUL entry so mid-operation changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            if (accept && last_chunk) begin
                mode_q <= mode;
            end
            if (state_q == MUL && mul_last && mode_q) begin
                acc_q <= acc_q + ACC_W'(psum);
            end
        end
    end

    always_comb begin
        vis = '0;
        if (mode) begin
            vis[ACC_W-1:0] = acc_q;
        end else begin
            vis[PW-1:0] = prod_q;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;

    always_comb begin
        vis         = '0;
        vis[PW-1:0] = prod_q;
    end
`endif

    assign out  = vis[{sel, 3'b000} +: 8];
    assign busy = (state_q == MUL);
    assign done = (state_q == DONE);

endmodule
